spi_slave_responder: RTL

Synthesizable SPI responder (slave) forming the far end of the SoC's SPI master port (sclk/ss/mosi driven by master, miso returned).
Oversamples the SPI pins in the io_clock domain and deframes MOSI into bytes on a valid/ready stream. Serializes bytes from a one-entry TX holding register onto MISO.
Used as an on-chip loopback peripheral and as the SPI device model in top-level simulation benches.

---
 rtl/spi_slave_responder_pkg.sv | 23 ++
 rtl/spi_slave_responder_if.sv | 30 +++
 rtl/spi_slave_responder_pin_sync.sv | 42 ++++
 rtl/spi_slave_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared types for the SPI responder: FSM states, SPI mode pair, synchronizer depth default.
package spi_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam int DEFAULT_SYNC_STAGES = 2;

   function automatic spi_mode_t make_mode(input logic cpol, input logic cpha);
      spi_mode_t m;
      m.cpol = cpol;
      m.cpha = cpha;
      return m;
   endfunction

endpackage

// File: rtl/spi_slave_responder_if.sv
// Bundle of SPI pins, RX/TX streams and status for the SPI responder.
interface spi_slave_responder_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  io_spi_sclk;
   logic                  io_spi_ss;
   logic                  io_spi_mosi;
   logic                  io_spi_miso;
   logic                  io_spi_miso_oe;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  overrun;
   logic                  underrun;
   logic                  status_clear;
   logic                  busy;

   modport slave (
      input  io_spi_sclk, io_spi_ss, io_spi_mosi, rx_ready, tx_valid, tx_data, status_clear,
      output io_spi_miso, io_spi_miso_oe, rx_valid, rx_data, tx_ready, overrun, underrun, busy
   );

   modport master (
      output io_spi_sclk, io_spi_ss, io_spi_mosi, rx_ready, tx_valid, tx_data, status_clear,
      input  io_spi_miso, io_spi_miso_oe, rx_valid, rx_data, tx_ready, overrun, underrun, busy
   );
endinterface

// File: rtl/spi_slave_responder_pin_sync.sv
// Multi-flop pin synchronizer with optional rise/fall detection on the synchronized level.
module spi_pin_sync #(
   parameter int             WIDTH     = 1,
   parameter int             STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit             EDGES     = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign dout = chain[STAGES-1];

   generate
      if (EDGES) begin : g_edges
         logic [WIDTH-1:0] prev;
         always_ff @(posedge clk) begin
            if (rst) prev <= RESET_VAL;
            else     prev <= dout;
         end
         assign rise = dout & ~prev;
         assign fall = ~dout & prev;
      end else begin : g_no_edges
         assign rise = '0;
         assign fall = '0;
      end
   endgenerate
endmodule

// File: rtl/spi_slave_responder.sv
// SPI responder: oversampled pins, MOSI deframed to an RX stream, MISO fed from a one-entry TX holding register.
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter bit                    CPOL        = 1'b0,
   parameter bit                    CPHA        = 1'b0,
   parameter bit                    MSB_FIRST   = 1'b1,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = {DATA_WIDTH{1'b1}},
   parameter int                    SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input logic                  io_clock,
   input logic                  io_reset,
   spi_slave_responder_if.slave bus
);
   localparam spi_mode_t       MODE = make_mode(CPOL, CPHA);
   localparam int              CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w, input logic b);
      return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
   endfunction

   logic unused_sclk_level, sclk_rise, sclk_fall;
   logic ss_s, ss_rise, ss_fall;
   logic mosi_s, unused_mosi_rise, unused_mosi_fall;

   spi_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(CPOL), .EDGES(1'b1)) u_sclk_sync (
      .clk(io_clock), .rst(io_reset), .din(bus.io_spi_sclk),
      .dout(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall));
   spi_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGES(1'b1)) u_ss_sync (
      .clk(io_clock), .rst(io_reset), .din(bus.io_spi_ss),
      .dout(ss_s), .rise(ss_rise), .fall(ss_fall));
   spi_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGES(1'b0)) u_mosi_sync (
      .clk(io_clock), .rst(io_reset), .din(bus.io_spi_mosi),
      .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   logic leading, trailing, sample_edge, shift_edge;
   assign leading     = MODE.cpol ? sclk_fall : sclk_rise;
   assign trailing    = MODE.cpol ? sclk_rise : sclk_fall;
   assign sample_edge = MODE.cpha ? trailing : leading;
   assign shift_edge  = MODE.cpha ? leading  : trailing;

   spi_state_e state, state_next;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] tx_shift, rx_shift, hold, rx_data_q;
   logic [SYNC_STAGES:0]  settle;
   logic armed, hold_full, reload_pending;
   logic miso_q, miso_oe_q, rx_valid_q, overrun_q, underrun_q;
   logic busy_c, start_frame, end_frame, do_sample, do_shift, load_word, take_hold, word_done;

   always_ff @(posedge io_clock) begin
      if (io_reset) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ss_fall && armed) state_next = SHIFT;
         SHIFT:   if (ss_rise)          state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_c      = (state == SHIFT);
      start_frame = (state == IDLE) && ss_fall && armed;
      end_frame   = (state == SHIFT) && ss_rise;
      do_sample   = (state == SHIFT) && !ss_rise && sample_edge;
      do_shift    = (state == SHIFT) && !ss_rise && shift_edge;
      load_word   = start_frame || (do_shift && reload_pending);
      take_hold   = load_word && hold_full;
      word_done   = do_sample && (bit_cnt == LAST);
   end

   logic [DATA_WIDTH-1:0] load_value, rx_next;
   logic tx_accept;
   assign load_value = hold_full ? hold : DEFAULT_TX;
   assign rx_next    = shift_in(rx_shift, mosi_s);
   assign tx_accept  = bus.tx_valid && !hold_full;

   // A select that is already low when reset releases must not start a frame;
   // the synchronizers need to flush and ss must be seen high first.
   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         settle <= {settle[SYNC_STAGES-1:0], 1'b1};
         armed  <= armed | (settle[SYNC_STAGES] & ss_s);
      end
   end

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         bit_cnt <= '0; tx_shift <= '0; rx_shift <= '0; hold <= '0; rx_data_q <= '0;
         hold_full <= 1'b0; reload_pending <= 1'b0; miso_q <= 1'b0; miso_oe_q <= 1'b0;
         rx_valid_q <= 1'b0; overrun_q <= 1'b0; underrun_q <= 1'b0;
      end else begin
         if (tx_accept) hold <= bus.tx_data;
         hold_full <= (hold_full && !take_hold) || tx_accept;
         if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
         overrun_q  <= (word_done && rx_valid_q && !bus.rx_ready) | (overrun_q & ~bus.status_clear);
         underrun_q <= (load_word && !hold_full) | (underrun_q & ~bus.status_clear);
         if (end_frame) begin
            bit_cnt <= '0; miso_q <= 1'b0; miso_oe_q <= 1'b0; reload_pending <= 1'b0;
         end else begin
            // CPHA=1 defers the first bit to the first leading edge.
            if (start_frame) begin
               miso_oe_q <= 1'b1; bit_cnt <= '0; reload_pending <= 1'b0;
               if (!MODE.cpha) begin
                  miso_q   <= first_bit(load_value);
                  tx_shift <= shift_out(load_value);
               end else begin
                  tx_shift <= load_value;
               end
            end
            if (do_shift) begin
               if (reload_pending) begin
                  miso_q <= first_bit(load_value); tx_shift <= shift_out(load_value);
                  reload_pending <= 1'b0;
               end else begin
                  miso_q <= first_bit(tx_shift); tx_shift <= shift_out(tx_shift);
               end
            end
            if (do_sample) begin
               rx_shift <= rx_next;
               if (bit_cnt == LAST) begin
                  bit_cnt <= '0; reload_pending <= 1'b1;
                  if (!rx_valid_q || bus.rx_ready) begin
                     rx_data_q <= rx_next; rx_valid_q <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign bus.io_spi_miso    = miso_q;
   assign bus.io_spi_miso_oe = miso_oe_q;
   assign bus.rx_valid       = rx_valid_q;
   assign bus.rx_data        = rx_data_q;
   assign bus.tx_ready       = !hold_full;
   assign bus.overrun        = overrun_q;
   assign bus.underrun       = underrun_q;
   assign bus.busy           = busy_c;
endmodule
